// File: rtl/lgn_frame_driver.sv
// lgn_frame_driver: binarizes and packs one pixel frame into the LGN classifier, then decodes its verdict.
// Ports: clk/rst_n clock and async active-low reset; s_pixel/s_valid/s_ready pixel stream in;
// frame_abort drops a partial frame; lgn_ui_in/lgn_write_enable classifier byte load port;
// lgn_uo_out classifier segments, echo and score; res_* decoded result with valid/ready handshake.
module lgn_frame_driver #(
    parameter int         PIXELS        = 784,
    parameter logic [7:0] THRESHOLD     = 8'd128,
    parameter int         SETTLE_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  s_pixel,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic        frame_abort,
    output logic [7:0]  lgn_ui_in,
    output logic        lgn_write_enable,
    input  logic [15:0] lgn_uo_out,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [3:0]  res_class,
    output logic [7:0]  res_score,
    output logic        res_err
);
    localparam int PW    = $clog2(PIXELS);
    localparam int BYTES = PIXELS / 8;
    localparam int BW    = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam int SW    = $clog2(SETTLE_CYCLES + 1);
    localparam logic [PW-1:0] LAST_PIX    = PW'(PIXELS - 1);
    localparam logic [BW-1:0] LAST_BYTE   = BW'(BYTES - 1);
    localparam logic [SW-1:0] LAST_SETTLE = SW'(SETTLE_CYCLES);

    typedef enum logic [1:0] {LOAD, SETTLE, RESULT} state_t;

    state_t          r_state, w_next;
    logic [PW-1:0]   r_pix_cnt;
    logic [BW-1:0]   r_byte_cnt;
    logic [SW-1:0]   r_settle_cnt;
    logic [7:0]      r_pack;
    logic [7:0]      w_pack_next;
    logic            w_take, w_byte_done, w_frame_done, w_settle_done;
    logic [3:0]      w_class;

    assign s_ready       = (r_state == LOAD);
    assign res_valid     = (r_state == RESULT);
    // A pixel offered alongside frame_abort is dropped.
    assign w_take        = s_ready & s_valid & ~frame_abort;
    assign w_pack_next   = {r_pack[6:0], s_pixel >= THRESHOLD};
    assign w_byte_done   = w_take & (r_pix_cnt[2:0] == 3'd7);
    assign w_frame_done  = w_byte_done & (r_pix_cnt == LAST_PIX) & (r_byte_cnt == LAST_BYTE);
    // Settle count 0 is the final write cycle; capture after SETTLE_CYCLES more.
    assign w_settle_done = (r_state == SETTLE) & (r_settle_cnt == LAST_SETTLE);

    always_comb begin
        w_next = frame_abort                          ? LOAD   :
                 w_frame_done                         ? SETTLE :
                 w_settle_done                        ? RESULT :
                 (r_state == RESULT && res_ready)     ? LOAD   : r_state;
    end

    always_comb begin
        w_class = 4'hF;
        case (lgn_uo_out[6:0])
            7'h3F: w_class = 4'd0;
            7'h06: w_class = 4'd1;
            7'h5B: w_class = 4'd2;
            7'h4F: w_class = 4'd3;
            7'h66: w_class = 4'd4;
            7'h6D: w_class = 4'd5;
            7'h7C: w_class = 4'd6;
            7'h07: w_class = 4'd7;
            7'h7F: w_class = 4'd8;
            7'h67: w_class = 4'd9;
            default: w_class = 4'hF;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= LOAD;
        else
            r_state <= w_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pix_cnt        <= '0;
            r_byte_cnt       <= '0;
            r_settle_cnt     <= '0;
            r_pack           <= '0;
            lgn_ui_in        <= '0;
            lgn_write_enable <= 1'b0;
            res_class        <= '0;
            res_score        <= '0;
            res_err          <= 1'b0;
        end else if (frame_abort) begin
            r_pix_cnt        <= '0;
            r_byte_cnt       <= '0;
            r_settle_cnt     <= '0;
            r_pack           <= '0;
            lgn_write_enable <= 1'b0;
        end else begin
            lgn_write_enable <= w_byte_done;
            r_settle_cnt     <= (r_state == SETTLE && !w_settle_done) ? r_settle_cnt + SW'(1) : '0;
            if (w_take) begin
                r_pack    <= w_pack_next;
                r_pix_cnt <= w_frame_done ? '0 : r_pix_cnt + PW'(1);
            end
            if (w_byte_done) begin
                lgn_ui_in  <= w_pack_next;
                r_byte_cnt <= w_frame_done ? '0 : r_byte_cnt + BW'(1);
            end
            if (w_settle_done) begin
                res_class <= w_class;
                res_score <= lgn_uo_out[15:8];
                res_err   <= (w_class == 4'hF) | ~lgn_uo_out[7];
            end
        end
    end
endmodule

// File: tb/tb_lgn_frame_driver.sv
// tb_lgn_frame_driver: directed frame vectors plus abort, handshake and async-reset sequences.
module tb_lgn_frame_driver;
    localparam int PIX = 784;

    typedef struct {
        logic [7:0] pe;
        logic [7:0] po;
        logic [6:0] seg;
        logic       echo_bad;
        logic [7:0] score;
        logic [7:0] exp_byte;
        logic [3:0] exp_class;
        logic       exp_err;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  s_pixel;
    logic        s_valid;
    logic        s_ready;
    logic        frame_abort;
    logic [7:0]  lgn_ui_in;
    logic        lgn_write_enable;
    logic [15:0] lgn_uo_out;
    logic        res_valid;
    logic        res_ready;
    logic [3:0]  res_class;
    logic [7:0]  res_score;
    logic        res_err;
    logic [7:0]  tb_score;
    logic [6:0]  tb_seg;
    logic        tb_echo_bad;

    always #5 clk = ~clk;

    // Classifier stand-in: echo bit is ~write_enable unless a fault is injected.
    assign lgn_uo_out = {tb_score, ~lgn_write_enable ^ tb_echo_bad, tb_seg};

    lgn_frame_driver #(.PIXELS(PIX), .THRESHOLD(8'd128), .SETTLE_CYCLES(2)) dut (
        .clk(clk), .rst_n(rst_n), .s_pixel(s_pixel), .s_valid(s_valid), .s_ready(s_ready),
        .frame_abort(frame_abort), .lgn_ui_in(lgn_ui_in), .lgn_write_enable(lgn_write_enable),
        .lgn_uo_out(lgn_uo_out), .res_valid(res_valid), .res_ready(res_ready),
        .res_class(res_class), .res_score(res_score), .res_err(res_err)
    );

    int n_cmp = 0;
    int n_fail = 0;
    int wr_cnt = 0;
    int wr_bad = 0;
    int space_bad = 0;
    int ncyc = 0;
    int last_wr = -100;
    logic [7:0] exp_byte = 8'h00;
    vec_t vecs[13];

    always @(negedge clk) begin
        ncyc++;
        if (lgn_write_enable === 1'b1) begin
            wr_cnt++;
            if (lgn_ui_in !== exp_byte) wr_bad++;
            if (ncyc - last_wr < 8) space_bad++;
            last_wr = ncyc;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send_frame(input logic [7:0] pe, input logic [7:0] po, input bit gap);
        int i = 0;
        int c = 0;
        int stalls = 0;
        logic rdy;
        while (i < PIX && c < 2 * PIX) begin
            if (gap && (c % 5 == 4)) begin
                s_valid = 1'b0;
                s_pixel = 8'hFF;
            end else begin
                s_valid = 1'b1;
                s_pixel = (i % 2 == 1) ? po : pe;
            end
            rdy = s_ready;
            @(posedge clk);
            #1;
            if (s_valid) begin
                if (rdy !== 1'b1) stalls++;
                i++;
            end
            c++;
        end
        s_valid = 1'b0;
        chk("no_stall", 32'(stalls), 32'd0);
    endtask

    task automatic wait_result();
        int k = 0;
        while (res_valid !== 1'b1 && k < 20) begin
            @(posedge clk);
            #1;
            k++;
        end
        chk("latency", 32'(k), 32'd3);
    endtask

    task automatic run_vec(input vec_t v, input bit gap);
        int w0, b0, s0, w1;
        int hold_bad = 0;
        tb_seg = v.seg;
        tb_score = v.score;
        tb_echo_bad = v.echo_bad;
        exp_byte = v.exp_byte;
        w0 = wr_cnt;
        b0 = wr_bad;
        s0 = space_bad;
        send_frame(v.pe, v.po, gap);
        wait_result();
        chk("res_class", 32'(res_class), 32'(v.exp_class));
        chk("res_score", 32'(res_score), 32'(v.score));
        chk("res_err", 32'(res_err), 32'(v.exp_err));
        chk("write_count", 32'(wr_cnt - w0), 32'd98);
        chk("write_bytes_bad", 32'(wr_bad - b0), 32'd0);
        chk("write_spacing_bad", 32'(space_bad - s0), 32'd0);
        tb_seg = ~v.seg;
        tb_score = ~v.score;
        s_valid = 1'b1;
        s_pixel = 8'hFF;
        w1 = wr_cnt;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (res_valid !== 1'b1 || s_ready !== 1'b0 || res_class !== v.exp_class ||
                res_score !== v.score || res_err !== v.exp_err) hold_bad++;
        end
        chk("hold_stable_bad", 32'(hold_bad), 32'd0);
        chk("hold_no_accept", 32'(wr_cnt - w1), 32'd0);
        s_valid = 1'b0;
        res_ready = 1'b1;
        @(posedge clk);
        #1;
        res_ready = 1'b0;
        chk("release_valid_ready", 32'({res_valid, s_ready}), 32'b01);
    endtask

    initial begin
        vec_t va;
        int w0;
        vecs[0]  = '{8'd255, 8'd255, 7'h7F, 1'b0, 8'h11, 8'hFF, 4'd8,  1'b0};
        vecs[1]  = '{8'd0,   8'd255, 7'h7C, 1'b0, 8'hA5, 8'h55, 4'd6,  1'b0};
        vecs[2]  = '{8'd127, 8'd128, 7'h3F, 1'b0, 8'h00, 8'h55, 4'd0,  1'b0};
        vecs[3]  = '{8'd128, 8'd127, 7'h00, 1'b0, 8'h5A, 8'hAA, 4'hF,  1'b1};
        vecs[4]  = '{8'd200, 8'd10,  7'h7F, 1'b1, 8'h80, 8'hAA, 4'd8,  1'b1};
        vecs[5]  = '{8'd0,   8'd0,   7'h06, 1'b0, 8'hFF, 8'h00, 4'd1,  1'b0};
        vecs[6]  = '{8'd128, 8'd128, 7'h5B, 1'b0, 8'h21, 8'hFF, 4'd2,  1'b0};
        vecs[7]  = '{8'd255, 8'd0,   7'h4F, 1'b0, 8'h32, 8'hAA, 4'd3,  1'b0};
        vecs[8]  = '{8'd1,   8'd130, 7'h66, 1'b0, 8'h43, 8'h55, 4'd4,  1'b0};
        vecs[9]  = '{8'd0,   8'd0,   7'h6D, 1'b0, 8'h54, 8'h00, 4'd5,  1'b0};
        vecs[10] = '{8'd255, 8'd255, 7'h07, 1'b0, 8'h65, 8'hFF, 4'd7,  1'b0};
        vecs[11] = '{8'd0,   8'd255, 7'h67, 1'b0, 8'h76, 8'h55, 4'd9,  1'b0};
        vecs[12] = '{8'd10,  8'd10,  7'h7D, 1'b0, 8'h87, 8'h00, 4'hF,  1'b1};

        rst_n = 1'b0;
        s_valid = 1'b0;
        s_pixel = 8'h00;
        frame_abort = 1'b0;
        res_ready = 1'b0;
        tb_seg = 7'h00;
        tb_score = 8'h00;
        tb_echo_bad = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_state", 32'({s_ready, lgn_write_enable, lgn_ui_in, res_valid, res_class, res_score, res_err}),
            32'({1'b1, 1'b0, 8'h00, 1'b0, 4'h0, 8'h00, 1'b0}));
        rst_n = 1'b1;
        res_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        res_ready = 1'b0;
        chk("stray_res_ready", 32'({s_ready, res_valid}), 32'b10);

        for (int v = 0; v < 13; v++) run_vec(vecs[v], v % 2 == 1);

        // Abort a partial frame in the same cycle as a pixel handshake.
        exp_byte = 8'hFF;
        w0 = wr_cnt;
        for (int i = 0; i < 401; i++) begin
            s_valid = 1'b1;
            s_pixel = 8'd255;
            @(posedge clk);
            #1;
        end
        frame_abort = 1'b1;
        @(posedge clk);
        #1;
        frame_abort = 1'b0;
        s_valid = 1'b0;
        chk("abort_we_low", 32'(lgn_write_enable), 32'd0);
        repeat (10) @(posedge clk);
        #1;
        chk("abort_partial_writes", 32'(wr_cnt - w0), 32'd50);
        chk("abort_state", 32'({s_ready, res_valid}), 32'b10);
        run_vec(vecs[1], 1'b0);

        // Asynchronous reset while settling.
        tb_seg = 7'h66;
        tb_score = 8'h99;
        tb_echo_bad = 1'b0;
        exp_byte = 8'hFF;
        send_frame(8'd255, 8'd255, 1'b0);
        @(posedge clk);
        #1;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset_state", 32'({s_ready, lgn_write_enable, lgn_ui_in, res_valid, res_class, res_score, res_err}),
            32'({1'b1, 1'b0, 8'h00, 1'b0, 4'h0, 8'h00, 1'b0}));
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        va = '{8'd255, 8'd255, 7'h66, 1'b0, 8'h99, 8'hFF, 4'd4, 1'b0};
        run_vec(va, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end
endmodule
